// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter
// Shares one 32-bit tx FIFO write port between the residual word stream and
// the 128-bit coefficient block stream. Each packet is prefixed with a header
// {HDR_TAG, src, mode, 5'b0, seq}. Packets are atomic. Round-robin
// arbitration happens only in IDLE.
// Source encoding: 0 = residual, 1 = coefficient. last_src resets to 1, so the
// first tie goes to the residual stream.
module tx_stream_arbiter #(
  parameter logic [7:0]  HDR_TAG    = 8'hA5,
  parameter int          COEF_BEATS = 4,
  // Value pkt_seq takes on reset; 0 in normal use.
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      res_valid,
  input  logic [31:0]               res_data,
  input  logic                      res_last,
  output logic                      res_ready,
  input  logic                      coef_valid,
  input  logic [32*COEF_BEATS-1:0]  coef_data,
  output logic                      coef_ready,
  input  logic [1:0]                mode,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [31:0]               fifo_din,
  output logic                      busy
);

  localparam int BW = (COEF_BEATS > 1) ? $clog2(COEF_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(COEF_BEATS - 1);
  localparam logic SRC_RES  = 1'b0;
  localparam logic SRC_COEF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RES  = 2'd2,
    ST_COEF = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               pkt_seq_q, pkt_seq_d;
  logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
  logic                      last_src_q, last_src_d;
  logic [1:0]                hdr_mode_q, hdr_mode_d;
  logic [32*COEF_BEATS-1:0]  shift_q, shift_d;

  // Unmasked outputs; forced to zero while reset is held.
  logic        res_ready_c;
  logic        coef_ready_c;
  logic        wr_en_c;
  logic [31:0] din_c;
  logic        grant_coef;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pkt_seq_q  <= SEQ_INIT;
      beat_cnt_q <= '0;
      last_src_q <= SRC_COEF;
      hdr_mode_q <= 2'b00;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      pkt_seq_q  <= pkt_seq_d;
      beat_cnt_q <= beat_cnt_d;
      last_src_q <= last_src_d;
      hdr_mode_q <= hdr_mode_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state logic and combinational outputs; fifo_full freezes every state.
  always_comb begin
    state_d      = state_q;
    pkt_seq_d    = pkt_seq_q;
    beat_cnt_d   = beat_cnt_q;
    last_src_d   = last_src_q;
    hdr_mode_d   = hdr_mode_q;
    shift_d      = shift_q;
    res_ready_c  = 1'b0;
    coef_ready_c = 1'b0;
    wr_en_c      = 1'b0;
    din_c        = 32'h0;
    // On a tie the source that did not go last wins.
    grant_coef   = coef_valid & (~res_valid | (last_src_q == SRC_RES));

    case (state_q)
      ST_IDLE: begin
        if (!fifo_full && (res_valid || coef_valid)) begin
          hdr_mode_d = mode;
          state_d    = ST_HDR;
          if (grant_coef) begin
            last_src_d   = SRC_COEF;
            coef_ready_c = 1'b1;
            shift_d      = coef_data;
          end else begin
            last_src_d = SRC_RES;
          end
        end
      end

      ST_HDR: begin
        din_c   = {HDR_TAG, last_src_q, hdr_mode_q, 5'b00000, pkt_seq_q};
        wr_en_c = ~fifo_full;
        if (!fifo_full) begin
          pkt_seq_d = pkt_seq_q + 16'd1;
          state_d   = (last_src_q == SRC_COEF) ? ST_COEF : ST_RES;
        end
      end

      ST_RES: begin
        res_ready_c = ~fifo_full;
        din_c       = res_data;
        wr_en_c     = res_valid & ~fifo_full;
        if (res_valid && !fifo_full && res_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_COEF: begin
        din_c   = shift_q[31:0];
        wr_en_c = ~fifo_full;
        if (!fifo_full) begin
          shift_d = shift_q >> 32;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign res_ready  = res_ready_c & ~reset;
  assign coef_ready = coef_ready_c & ~reset;
  assign fifo_wr_en = wr_en_c & ~reset;
  assign fifo_din   = reset ? 32'h0 : din_c;
  assign busy       = (state_q != ST_IDLE) & ~reset;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Bench for tx_stream_arbiter: queue-driven producers, a packet-level model
// of the expected FIFO write stream checked every cycle, and literal checks
// on the captured write log for each directed test.
module tb_tx_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         res_valid, res_last, coef_valid, fifo_full;
  logic [31:0]  res_data;
  logic [127:0] coef_data;
  logic [1:0]   mode;

  logic        res_ready, coef_ready, fifo_wr_en, busy;
  logic [31:0] fifo_din;
  logic        res_ready2, coef_ready2, fifo_wr_en2, busy2;
  logic [31:0] fifo_din2;

  always #5 clk = ~clk;

  tx_stream_arbiter dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .mode(mode), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy)
  );

  // Same stimulus, sequence number starting at FFFF to exercise the wrap.
  tx_stream_arbiter #(.SEQ_INIT(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready2),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready2),
    .mode(mode), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en2), .fifo_din(fifo_din2),
    .busy(busy2)
  );

  typedef struct packed {
    logic        bubble;
    logic        last;
    logic [31:0] data;
  } res_ent_t;

  res_ent_t     res_q[$];
  logic [127:0] coef_q[$];
  logic         full_q[$];
  logic [31:0]  wlog[$];
  logic [31:0]  wlog2[$];
  int           wcyc[$];
  int           cr_pulses = 0;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_miss = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Producers: present queue heads, pop on handshake seen before the edge.
  logic res_hs = 1'b0, coef_hs = 1'b0, res_bub = 1'b0;
  always begin
    @(negedge clk);
    res_hs  = res_valid && res_ready && !reset;
    coef_hs = coef_valid && coef_ready && !reset;
    @(posedge clk);
    #1;
    if ((res_hs || res_bub) && res_q.size() > 0) void'(res_q.pop_front());
    if (coef_hs && coef_q.size() > 0) void'(coef_q.pop_front());
    res_bub = 1'b0;
    if (res_q.size() > 0 && res_q[0].bubble) begin
      res_valid = 1'b0; res_last = 1'b0; res_bub = 1'b1;
    end else if (res_q.size() > 0) begin
      res_valid = 1'b1; res_data = res_q[0].data; res_last = res_q[0].last;
    end else begin
      res_valid = 1'b0; res_last = 1'b0;
    end
    coef_valid = (coef_q.size() > 0);
    if (coef_q.size() > 0) coef_data = coef_q[0];
    fifo_full = (full_q.size() > 0) ? full_q.pop_front() : 1'b0;
  end

  // Packet-level model: idle/packet flag, queue of words still owed, open residual flag.
  logic        m_idle = 1'b1, m_res_open = 1'b0, m_last = 1'b1, m_win = 1'b0;
  logic [15:0] m_seq = 16'h0;
  logic [31:0] e1_q[$];
  logic [31:0] e2_q[$];

  always @(negedge clk) begin
    if (fifo_wr_en && !reset) begin wlog.push_back(fifo_din); wcyc.push_back(cyc); end
    if (fifo_wr_en2 && !reset) wlog2.push_back(fifo_din2);
    if (coef_ready && !reset) cr_pulses++;
    if (reset) begin
      chk("rst_wr", fifo_wr_en, 0);   chk("rst_din", fifo_din, 0);
      chk("rst_rr", res_ready, 0);    chk("rst_cr", coef_ready, 0);
      chk("rst_busy", busy, 0);       chk("rst_wr2", fifo_wr_en2, 0);
      m_idle = 1'b1; m_res_open = 1'b0; m_last = 1'b1; m_seq = 16'h0;
      e1_q.delete(); e2_q.delete();
    end else if (m_idle) begin
      m_win = 1'b0;
      if (!fifo_full && (res_valid || coef_valid)) begin
        if (res_valid && coef_valid) m_win = (m_last == 1'b0);
        else m_win = coef_valid;
      end
      chk("idle_cr", coef_ready, m_win);  chk("idle_cr2", coef_ready2, m_win);
      chk("idle_rr", res_ready, 0);       chk("idle_wr", fifo_wr_en, 0);
      chk("idle_busy", busy, 0);          chk("idle_busy2", busy2, 0);
      if (!fifo_full && (res_valid || coef_valid)) begin
        e1_q.push_back({8'hA5, m_win, mode, 5'b0, m_seq});
        e2_q.push_back({8'hA5, m_win, mode, 5'b0, m_seq + 16'hFFFF});
        m_seq  = m_seq + 16'd1;
        m_last = m_win;
        m_idle = 1'b0;
        if (m_win) begin
          for (int i = 0; i < 4; i++) begin
            e1_q.push_back(coef_data[32*i +: 32]);
            e2_q.push_back(coef_data[32*i +: 32]);
          end
        end else begin
          m_res_open = 1'b1;
        end
      end
    end else begin
      chk("pkt_busy", busy, 1);  chk("pkt_busy2", busy2, 1);
      chk("pkt_cr", coef_ready, 0);
      if (e1_q.size() > 0) begin
        chk("owed_rr", res_ready, 0);
        chk("owed_wr", fifo_wr_en, !fifo_full);  chk("owed_wr2", fifo_wr_en2, !fifo_full);
        chk("owed_din", fifo_din, e1_q[0]);      chk("owed_din2", fifo_din2, e2_q[0]);
        if (!fifo_full) begin
          void'(e1_q.pop_front());
          void'(e2_q.pop_front());
          if (e1_q.size() == 0 && !m_res_open) m_idle = 1'b1;
        end
      end else begin
        chk("res_rr", res_ready, !fifo_full);  chk("res_rr2", res_ready2, !fifo_full);
        chk("res_wr", fifo_wr_en, res_valid && !fifo_full);
        chk("res_wr2", fifo_wr_en2, res_valid && !fifo_full);
        if (res_valid && !fifo_full) begin
          chk("res_din", fifo_din, res_data);  chk("res_din2", fifo_din2, res_data);
          if (res_last) begin m_res_open = 1'b0; m_idle = 1'b1; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    res_q.delete(); coef_q.delete(); full_q.delete();
    step();
    step();
    reset = 1'b0;
    wlog.delete(); wlog2.delete(); wcyc.delete();
    cr_pulses = 0;
  endtask

  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while (!(res_q.size() == 0 && coef_q.size() == 0 && full_q.size() == 0 &&
             !busy && !res_valid && !coef_valid) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      n_vec++; n_miss++;
      $display("FAIL %s: timeout, busy=%0b still pending", name, busy);
    end
  endtask

  task automatic push_res(input logic bubble, input logic last, input logic [31:0] data);
    res_ent_t e;
    e.bubble = bubble; e.last = last; e.data = data;
    res_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; res_valid = 1'b0; res_data = 32'h0; res_last = 1'b0;
    coef_valid = 1'b0; coef_data = 128'h0; mode = 2'd0; fifo_full = 1'b0;
    apply_reset();
    chk("reset_busy_lit", busy, 0);
    chk("reset_wr_lit", fifo_wr_en, 0);

    // T1: residual only, 3 words, mode 2
    mode = 2'd2;
    push_res(0, 0, 32'h1111_0001); push_res(0, 0, 32'h1111_0002); push_res(0, 1, 32'h1111_0003);
    wait_quiet("t1");
    $display("T1 residual: %0d writes", wlog.size());
    chk("t1_count", wlog.size(), 4);
    chk("t1_hdr", wlog[0], 32'hA540_0000);
    chk("t1_w1", wlog[1], 32'h1111_0001);
    chk("t1_w3", wlog[3], 32'h1111_0003);
    chk("t1_consec", wcyc[3] - wcyc[0], 3);

    // T2: coefficient only, mode 1
    apply_reset();
    mode = 2'd1;
    coef_q.push_back(128'h44444444_33333333_22222222_11111111);
    wait_quiet("t2");
    $display("T2 coefficient: %0d writes", wlog.size());
    chk("t2_count", wlog.size(), 5);
    chk("t2_hdr", wlog[0], 32'hA5A0_0000);
    chk("t2_b0", wlog[1], 32'h1111_1111);
    chk("t2_b3", wlog[4], 32'h4444_4444);
    chk("t2_consec", wcyc[4] - wcyc[0], 4);
    chk("t2_cr_once", cr_pulses, 1);

    // T3: both valid from reset, then a third tie
    apply_reset();
    mode = 2'd0;
    push_res(0, 0, 32'hA000_0001); push_res(1, 0, 32'h0); push_res(0, 1, 32'hA000_0002);
    push_res(0, 1, 32'hB000_0001);
    coef_q.push_back(128'hC1C1_0004_C1C1_0003_C1C1_0002_C1C1_0001);
    coef_q.push_back(128'hC2C2_0004_C2C2_0003_C2C2_0002_C2C2_0001);
    wait_quiet("t3");
    $display("T3 arbitration: %0d writes", wlog.size());
    chk("t3_count", wlog.size(), 15);
    chk("t3_hdr_res", wlog[0], 32'hA500_0000);
    chk("t3_hdr_coef", wlog[3], 32'hA580_0001);
    chk("t3_c1_b0", wlog[4], 32'hC1C1_0001);
    chk("t3_hdr_res2", wlog[8], 32'hA500_0002);
    chk("t3_hdr_coef2", wlog[10], 32'hA580_0003);
    chk("t3_c2_b3", wlog[14], 32'hC2C2_0004);
    chk("t3_cr_twice", cr_pulses, 2);

    // T4: fifo_full during IDLE, header and coef beat 2; then during residual data
    apply_reset();
    mode = 2'd3;
    full_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    coef_q.push_back(128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);
    wait_quiet("t4");
    $display("T4 full coef: %0d writes", wlog.size());
    chk("t4_count", wlog.size(), 5);
    chk("t4_hdr", wlog[0], 32'hA5E0_0000);
    chk("t4_b1", wlog[2], 32'hBBBB_0002);
    chk("t4_b2", wlog[3], 32'hCCCC_0003);
    chk("t4_span", wcyc[4] - wcyc[0], 5);
    chk("t4_cr_once", cr_pulses, 1);
    wlog.delete();
    full_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    push_res(0, 0, 32'h5555_0001); push_res(0, 1, 32'h5555_0002);
    wait_quiet("t4b");
    $display("T4 full residual: %0d writes", wlog.size());
    chk("t4b_count", wlog.size(), 3);
    chk("t4b_hdr", wlog[0], 32'hA560_0001);
    chk("t4b_w2", wlog[2], 32'h5555_0002);

    // T5: sequence wrap, seen on the instance that starts at FFFF
    apply_reset();
    mode = 2'd2;
    push_res(0, 1, 32'h7777_0001); push_res(0, 1, 32'h7777_0002);
    wait_quiet("t5");
    $display("T5 wrap: %0d writes", wlog2.size());
    chk("t5_count", wlog2.size(), 4);
    chk("t5_hdr_ffff", wlog2[0], 32'hA540_FFFF);
    chk("t5_hdr_0000", wlog2[2], 32'hA540_0000);
    chk("t5_main_hdr2", wlog[2], 32'hA540_0001);

    // T6: reset while residual word 2 is on offer
    apply_reset();
    mode = 2'd2;
    push_res(0, 0, 32'h9999_0001); push_res(0, 0, 32'h9999_0002); push_res(0, 1, 32'h9999_0003);
    for (int k = 0; k < 50 && wlog.size() < 2; k++) step();
    chk("t6_reached_w2", wlog.size(), 2);
    reset = 1'b1;
    res_q.delete();
    step();
    reset = 1'b0;
    chk("t6_busy_after", busy, 0);
    chk("t6_wr_after", fifo_wr_en, 0);
    wlog.delete();
    mode = 2'd1;
    push_res(0, 1, 32'h600D_0001);
    wait_quiet("t6");
    $display("T6 reset mid-packet: %0d writes after restart", wlog.size());
    chk("t6_count", wlog.size(), 2);
    chk("t6_hdr_seq0", wlog[0], 32'hA520_0000);
    chk("t6_w1", wlog[1], 32'h600D_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
